// File: rtl/sdram_slot_scheduler_if.sv
// sdram_slot_scheduler_if
//   Bundles the slot scheduler's request, response and SDRAM command
//   signals so that the scheduler and its environment connect through one port.
//
//   slave  modport : the scheduler itself.
//                    It receives requests and sdram_rdata.
//                    It drives commands, read data, wr_ready and phase.
//   master modport : the requester / controller side (mirror image).
//
//   Signals:
//     line_start   1   realign the 16-cycle slot phase
//     init_busy    1   SDRAM controller initialisation in progress
//     rd_req       1   video read request, sampled at phase 0
//     rd_addr      16  video read word address
//     rd_data      32  read word returned to the video side
//     rd_valid     1   one-cycle strobe qualifying rd_data
//     wr_req       1   host write request
//     wr_addr      16  host write address
//     wr_data      8   host write byte
//     wr_ready     1   write buffer can accept
//     mreq_n       1   active-low memory request strobe
//     rd_n         1   active-low read strobe
//     wr_n         1   active-low write strobe
//     rfsh_n       1   active-low refresh strobe
//     address      16  command address
//     wdata        8   command write byte
//     sdram_rdata  32  read data from the SDRAM controller
//     phase        4   current slot phase
interface sdram_slot_scheduler_if;
    logic        line_start;
    logic        init_busy;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        mreq_n;
    logic        rd_n;
    logic        wr_n;
    logic        rfsh_n;
    logic [15:0] address;
    logic [7:0]  wdata;
    logic [31:0] sdram_rdata;
    logic [3:0]  phase;

    modport slave (
        input  line_start, init_busy, rd_req, rd_addr, wr_req, wr_addr, wr_data,
               sdram_rdata,
        output rd_data, rd_valid, wr_ready, mreq_n, rd_n, wr_n, rfsh_n,
               address, wdata, phase
    );

    modport master (
        output line_start, init_busy, rd_req, rd_addr, wr_req, wr_addr, wr_data,
               sdram_rdata,
        input  rd_data, rd_valid, wr_ready, mreq_n, rd_n, wr_n, rfsh_n,
               address, wdata, phase
    );
endinterface

// File: rtl/sdram_slot_scheduler.sv
// sdram_slot_scheduler
//   Time-slots SDRAM access into a repeating 16-cycle frame.
//   - Phase 0 may issue a video read.
//     Its command is on the bus at phase 1, and its data returns at phase 9.
//   - Phase 8 issues either a buffered host write or a refresh.
//     That command is on the bus at phase 9.
//   - A refresh is forced after RFSH_MAX consecutive write slots.
//
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous active-high reset
//     bus   sdram_slot_scheduler_if.slave (requests, responses, commands)
//
//   Parameter:
//     RFSH_MAX  maximum consecutive write slots before a refresh (default 8)
//
//   Build option:
//     SDRAM_SCHED_WR_FIFO_EN  defined   -> 4-entry write FIFO
//                             undefined -> single-entry write register
module sdram_slot_scheduler #(
    parameter int RFSH_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    sdram_slot_scheduler_if.slave bus
);

`ifdef SDRAM_SCHED_WR_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam int STREAK_W = $clog2(RFSH_MAX + 1);
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]          phase_q;
    logic                rd_pend_q;
    logic [STREAK_W-1:0] streak_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [15:0]         buf_addr_q [DEPTH];
    logic [7:0]          buf_data_q [DEPTH];
    logic                mreq_n_q, rd_n_q, wr_n_q, rfsh_n_q;
    logic [15:0]         address_q;
    logic [7:0]          wdata_q;
    logic [31:0]         rd_data_q;
    logic                rd_valid_q;

    logic             full, push, pop;
    logic             slot_go, wr_slot, issue_rd, issue_wr, issue_rf, rd_done;
    logic [IDX_W-1:0] wr_idx;

    // wr_ready comes only from the registered count.
    // A pop in this cycle therefore cannot reopen the buffer until the next cycle.
    assign full = (cnt_q == CNT_W'(DEPTH));
    assign push = bus.wr_req && !full;

    // A command is issued only if the next cycle really is the command phase.
    // A line_start in the issuing cycle would jump the phase back to 0 instead.
    assign slot_go  = !bus.init_busy && !bus.line_start;
    assign issue_rd = slot_go && (phase_q == 4'd0) && bus.rd_req;
    assign wr_slot  = slot_go && (phase_q == 4'd8);
    assign issue_wr = wr_slot && (cnt_q != '0) && (streak_q < STREAK_W'(RFSH_MAX));
    assign issue_rf = wr_slot && !issue_wr;
    assign rd_done  = wr_slot && rd_pend_q;
    assign pop      = issue_wr;

    // Head of the buffer is always entry 0.
    // A new entry lands just past the surviving entries.
    assign wr_idx = IDX_W'(cnt_q - CNT_W'(pop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= '0;
            rd_pend_q  <= 1'b0;
            streak_q   <= '0;
            cnt_q      <= '0;
            mreq_n_q   <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            rfsh_n_q   <= 1'b1;
            address_q  <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            phase_q  <= bus.line_start ? 4'd0 : phase_q + 4'd1;
            cnt_q    <= cnt_q + CNT_W'(push) - CNT_W'(pop);
            mreq_n_q <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            rfsh_n_q <= 1'b1;

            if (issue_rd) begin
                mreq_n_q  <= 1'b0;
                rd_n_q    <= 1'b0;
                address_q <= bus.rd_addr;
            end
            if (issue_wr) begin
                mreq_n_q  <= 1'b0;
                wr_n_q    <= 1'b0;
                address_q <= buf_addr_q[0];
                wdata_q   <= buf_data_q[0];
                streak_q  <= streak_q + STREAK_W'(1);
            end
            if (issue_rf) begin
                mreq_n_q <= 1'b0;
                rfsh_n_q <= 1'b0;
                streak_q <= '0;
            end

            // An outstanding read lives only until phase 8 of its own slot.
            // A truncated slot or a busy controller at phase 8 drops it silently.
            if (issue_rd)
                rd_pend_q <= 1'b1;
            else if (bus.line_start || (phase_q == 4'd8))
                rd_pend_q <= 1'b0;

            rd_valid_q <= rd_done;
            if (rd_done)
                rd_data_q <= bus.sdram_rdata;
        end
    end

    // Buffer storage carries no reset.
    // Validity is tracked entirely by cnt_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (pop) begin
                buf_addr_q[i] <= buf_addr_q[i+1];
                buf_data_q[i] <= buf_data_q[i+1];
            end
        end
        if (push) begin
            buf_addr_q[wr_idx] <= bus.wr_addr;
            buf_data_q[wr_idx] <= bus.wr_data;
        end
    end

    assign bus.phase    = phase_q;
    assign bus.wr_ready = !full;
    assign bus.mreq_n   = mreq_n_q;
    assign bus.rd_n     = rd_n_q;
    assign bus.wr_n     = wr_n_q;
    assign bus.rfsh_n   = rfsh_n_q;
    assign bus.address  = address_q;
    assign bus.wdata    = wdata_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_sdram_slot_scheduler.sv
module tb_sdram_slot_scheduler;

    localparam logic [1:0] K_RD = 2'd1;
    localparam logic [1:0] K_WR = 2'd2;
    localparam logic [1:0] K_RF = 2'd3;

    typedef struct {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [7:0]  data;
    } cmd_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic track;

    cmd_t        cmd_q[$];
    logic [31:0] rdv_q[$];

    sdram_slot_scheduler_if bus();

    sdram_slot_scheduler #(.RFSH_MAX(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_cmd(input logic [1:0] kind, input logic [15:0] addr, input logic [7:0] data);
        cmd_t c;
        c.kind = kind;
        c.addr = addr;
        c.data = data;
        cmd_q.push_back(c);
    endtask

    // Scoreboard: commands and read returns are popped as the DUT produces them.
    cmd_t       mon_e;
    logic [1:0] mon_kind;
    logic [31:0] mon_d;
    always @(negedge clk) begin
        if (track && !rst) begin
            if (!bus.mreq_n || !bus.rd_n || !bus.wr_n || !bus.rfsh_n) begin
                mon_kind = !bus.rd_n ? K_RD : (!bus.wr_n ? K_WR : (!bus.rfsh_n ? K_RF : 2'd0));
                if (cmd_q.size() == 0) begin
                    chk("cmd_extra", {30'd0, mon_kind}, 32'd0);
                end else begin
                    mon_e = cmd_q.pop_front();
                    chk("cmd_kind", {30'd0, mon_kind}, {30'd0, mon_e.kind});
                    chk("cmd_mreq", {31'd0, bus.mreq_n}, 32'd0);
                    chk("cmd_phase", {28'd0, bus.phase}, (mon_e.kind == K_RD) ? 32'd1 : 32'd9);
                    if (mon_e.kind != K_RF)
                        chk("cmd_addr", {16'd0, bus.address}, {16'd0, mon_e.addr});
                    if (mon_e.kind == K_WR)
                        chk("cmd_wdata", {24'd0, bus.wdata}, {24'd0, mon_e.data});
                end
            end
            if (bus.rd_valid) begin
                if (rdv_q.size() == 0) begin
                    chk("rdv_extra", {31'd0, bus.rd_valid}, 32'd0);
                end else begin
                    mon_d = rdv_q.pop_front();
                    chk("rdv_data", bus.rd_data, mon_d);
                    chk("rdv_phase", {28'd0, bus.phase}, 32'd9);
                end
            end
        end
    end

    task automatic wait_phase(input logic [3:0] p);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.phase != p && n < 40);
        if (bus.phase != p)
            chk("wait_phase", {28'd0, bus.phase}, {28'd0, p});
    endtask

    task automatic check_reset();
        chk("rst_phase",   {28'd0, bus.phase},    32'd0);
        chk("rst_mreq_n",  {31'd0, bus.mreq_n},   32'd1);
        chk("rst_rd_n",    {31'd0, bus.rd_n},     32'd1);
        chk("rst_wr_n",    {31'd0, bus.wr_n},     32'd1);
        chk("rst_rfsh_n",  {31'd0, bus.rfsh_n},   32'd1);
        chk("rst_rd_valid",{31'd0, bus.rd_valid}, 32'd0);
        chk("rst_rd_data", bus.rd_data,           32'd0);
        chk("rst_address", {16'd0, bus.address},  32'd0);
        chk("rst_wdata",   {24'd0, bus.wdata},    32'd0);
        chk("rst_wr_ready",{31'd0, bus.wr_ready}, 32'd1);
    endtask

    // Called at a falling edge; asserts reset mid-cycle and releases it at the next falling edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1 check_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic end_test(input string name);
        track = 1'b0;
        chk({name, "_cmd_left"}, cmd_q.size(), 32'd0);
        chk({name, "_rdv_left"}, rdv_q.size(), 32'd0);
        cmd_q.delete();
        rdv_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic xfer;
        checks = 0;
        errors = 0;
        track  = 1'b0;
        rst    = 1'b1;
        bus.line_start  = 1'b0;
        bus.init_busy   = 1'b0;
        bus.rd_req      = 1'b0;
        bus.rd_addr     = '0;
        bus.wr_req      = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.sdram_rdata = '0;
        @(negedge clk);

        // Read after reset
        bus.rd_req = 1'b1;
        bus.rd_addr = 16'h1234;
        bus.sdram_rdata = 32'hDEADBEEF;
        push_cmd(K_RD, 16'h1234, 8'h00);
        push_cmd(K_RF, 16'h0000, 8'h00);
        rdv_q.push_back(32'hDEADBEEF);
        do_reset();
        track = 1'b1;
        wait_phase(1);
        bus.rd_req = 1'b0;
        wait_phase(9);
        wait_phase(10);
        end_test("read");

        // Single write then refresh
        do_reset();
        track = 1'b1;
        push_cmd(K_WR, 16'h0100, 8'h5A);
        push_cmd(K_RF, 16'h0000, 8'h00);
        wait_phase(3);
        bus.wr_req = 1'b1;
        bus.wr_addr = 16'h0100;
        bus.wr_data = 8'h5A;
        @(negedge clk);
        bus.wr_req = 1'b0;
`ifdef SDRAM_SCHED_WR_FIFO_EN
        chk("wr_ready_1push", {31'd0, bus.wr_ready}, 32'd1);
`else
        chk("wr_ready_1push", {31'd0, bus.wr_ready}, 32'd0);
`endif
        wait_phase(9);
        chk("wr_ready_popped", {31'd0, bus.wr_ready}, 32'd1);
        wait_phase(9);
        wait_phase(10);
        end_test("write");

        // Continuous writes: slots 1-8 write, 9 refresh, 10 write, then refresh once drained
        for (int s = 0; s < 11; s++) begin
            if (s == 8 || s == 10)
                push_cmd(K_RF, 16'h0000, 8'h00);
            else
                push_cmd(K_WR, 16'h0200 + 16'((s < 8) ? s : s - 1), 8'((s < 8) ? s : s - 1) ^ 8'hA5);
        end
        do_reset();
        track = 1'b1;
        n = 0;
        bus.wr_req = 1'b1;
        bus.wr_addr = 16'h0200;
        bus.wr_data = 8'hA5;
        xfer = bus.wr_ready;
        for (int c = 0; c < 172; c++) begin
            @(negedge clk);
            if (xfer) n++;
            if (n < 9) begin
                bus.wr_req  = 1'b1;
                bus.wr_addr = 16'h0200 + 16'(n);
                bus.wr_data = 8'(n) ^ 8'hA5;
                xfer = bus.wr_ready;
            end else begin
                bus.wr_req = 1'b0;
                xfer = 1'b0;
            end
        end
        bus.wr_req = 1'b0;
        chk("streak_pushes", n, 32'd9);
        end_test("streak");

        // Back-to-back pushes and buffer-full behaviour
        do_reset();
        track = 1'b1;
`ifdef SDRAM_SCHED_WR_FIFO_EN
        for (int i = 0; i < 4; i++)
            push_cmd(K_WR, 16'h0300 + 16'(i), 8'h30 + 8'(i));
        push_cmd(K_RF, 16'h0000, 8'h00);
        for (int i = 0; i < 4; i++) begin
            bus.wr_req  = 1'b1;
            bus.wr_addr = 16'h0300 + 16'(i);
            bus.wr_data = 8'h30 + 8'(i);
            @(negedge clk);
            chk("wr_ready_fill", {31'd0, bus.wr_ready}, (i < 3) ? 32'd1 : 32'd0);
        end
        bus.wr_req = 1'b0;
        wait_phase(9);
        chk("wr_ready_after_pop", {31'd0, bus.wr_ready}, 32'd1);
        for (int i = 0; i < 4; i++)
            wait_phase(9);
        wait_phase(10);
`else
        push_cmd(K_WR, 16'h0300, 8'h30);
        push_cmd(K_WR, 16'h0301, 8'h31);
        push_cmd(K_RF, 16'h0000, 8'h00);
        bus.wr_req  = 1'b1;
        bus.wr_addr = 16'h0300;
        bus.wr_data = 8'h30;
        @(negedge clk);
        chk("wr_ready_fill", {31'd0, bus.wr_ready}, 32'd0);
        bus.wr_addr = 16'h0301;
        bus.wr_data = 8'h31;
        wait_phase(9);
        chk("wr_ready_after_pop", {31'd0, bus.wr_ready}, 32'd1);
        @(negedge clk);
        bus.wr_req = 1'b0;
        wait_phase(9);
        wait_phase(9);
        wait_phase(10);
`endif
        end_test("fill");

        // init_busy holds everything off; pending write goes out once it falls
        bus.init_busy = 1'b1;
        bus.rd_req = 1'b1;
        bus.rd_addr = 16'h4444;
        bus.sdram_rdata = 32'h0BADF00D;
        push_cmd(K_WR, 16'h0500, 8'h77);
        push_cmd(K_RD, 16'h4444, 8'h00);
        push_cmd(K_RF, 16'h0000, 8'h00);
        rdv_q.push_back(32'h0BADF00D);
        do_reset();
        track = 1'b1;
        bus.wr_req  = 1'b1;
        bus.wr_addr = 16'h0500;
        bus.wr_data = 8'h77;
        @(negedge clk);
        bus.wr_req = 1'b0;
        wait_phase(9);
        chk("init_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("init_mreq_n", {31'd0, bus.mreq_n}, 32'd1);
        wait_phase(9);
        wait_phase(2);
        bus.init_busy = 1'b0;
        wait_phase(9);
        wait_phase(1);
        bus.rd_req = 1'b0;
        wait_phase(9);
        wait_phase(10);
        end_test("init");

        // line_start mid-slot drops an issued read
        bus.rd_req = 1'b1;
        bus.rd_addr = 16'h6666;
        bus.sdram_rdata = 32'h12345678;
        push_cmd(K_RD, 16'h6666, 8'h00);
        push_cmd(K_RF, 16'h0000, 8'h00);
        do_reset();
        track = 1'b1;
        wait_phase(1);
        bus.rd_req = 1'b0;
        wait_phase(5);
        bus.line_start = 1'b1;
        @(negedge clk);
        bus.line_start = 1'b0;
        chk("line_start_phase", {28'd0, bus.phase}, 32'd0);
        wait_phase(9);
        wait_phase(10);
        chk("dropped_rd_data", bus.rd_data, 32'd0);
        end_test("line");

        // Reset at phase 1 of a read aborts it
        bus.rd_req = 1'b1;
        bus.rd_addr = 16'h7777;
        bus.sdram_rdata = 32'hCAFEF00D;
        push_cmd(K_RD, 16'h7777, 8'h00);
        push_cmd(K_RF, 16'h0000, 8'h00);
        do_reset();
        track = 1'b1;
        wait_phase(1);
        bus.rd_req = 1'b0;
        do_reset();
        wait_phase(9);
        chk("abort_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        wait_phase(10);
        end_test("abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_slot_scheduler.md
SDRAM_SLOT_SCHEDULER -- requirements
Module: sdram_slot_scheduler

Interface
REQ-001 Parameter RFSH_MAX, default 8: maximum consecutive write slots allowed before a refresh slot is forced.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 line_start  input  1  one-cycle pulse; realigns the 16-cycle slot phase.
REQ-005 init_busy  input  1  SDRAM controller initialisation in progress.
REQ-006 rd_req / rd_addr  input  1 / 16  video read request and word address, sampled at phase 0.
REQ-007 rd_data / rd_valid  output  32 / 1  read word and its one-cycle valid strobe.
REQ-008 wr_req / wr_addr / wr_data  input  1 / 16 / 8  host write request, address and byte.
REQ-009 wr_ready  output  1  write buffer can accept; a transfer occurs when wr_req && wr_ready at a rising edge.
REQ-010 mreq_n, rd_n, wr_n, rfsh_n  output  1 each  active-low SDRAM command strobes.
REQ-011 address / wdata  output  16 / 8  command address and write byte.
REQ-012 sdram_rdata  input  32  read data from the SDRAM controller.
REQ-013 phase  output  4  current slot phase.

Function
REQ-014 The 4-bit phase counter increments every cycle and wraps from 15 to 0; when line_start is high, the next value is 0.
REQ-015 At phase 0, if rd_req=1 and init_busy=0, a read is issued: mreq_n=0, rd_n=0, address=rd_addr, all registered, for exactly the cycle at phase 1.
REQ-016 For an issued read, rd_data loads sdram_rdata at phase 8, rd_valid is high for exactly the cycle at phase 9, and rd_data holds until the next issued read.
REQ-017 At phase 8 with init_busy=0, exactly one of write or refresh is issued, registered and active for the cycle at phase 9.
REQ-018 A write is issued at phase 8 when the buffer is non-empty and wr_streak < RFSH_MAX.
  - Strobes: mreq_n=0, wr_n=0.
  - address and wdata come from the buffer head; the head entry is popped.
  - wr_streak increments.
REQ-019 Otherwise a refresh is issued at phase 8: mreq_n=0, rfsh_n=0, and wr_streak clears to 0.
REQ-020 wr_streak is ceil(log2(RFSH_MAX+1)) bits wide and never exceeds RFSH_MAX.
REQ-021 When no command is active, all strobes are 1; address and wdata hold their last value.
REQ-022 While init_busy=1, no command is issued, rd_valid stays 0, and wr_streak and buffer contents are frozen except for pushes.
REQ-023 Write buffer is FIFO-ordered, and wr_ready = !full, decoded from registered state.
REQ-024 Push and pop in the same cycle are both honoured, with occupancy unchanged.
REQ-025 A drain in the current cycle does not raise wr_ready in that same cycle.
REQ-026 A line_start pulse during phases 1-15 truncates that slot; a read already issued still produces rd_valid only if phase 9 is reached, otherwise the read data is dropped with no rd_valid.

Reset
REQ-027 On rst=1, the following clear immediately:
  - phase=0, wr_streak=0, buffer empty (contents discarded);
  - mreq_n=rd_n=wr_n=rfsh_n=1;
  - rd_valid=0, rd_data=0, address=0, wdata=0;
  - wr_ready=1.
REQ-028 Reset asserted mid-command aborts that command; after release, the first command is at phase 1 at the earliest.

Configuration
REQ-029 Macro SDRAM_SCHED_WR_FIFO_EN: when defined, the write buffer is a 4-entry FIFO; when undefined, it is a single-entry register.
  - Both builds behave identically for any sequence that never has more than one pending write.

Verification
REQ-030 After reset, with rd_req=1, rd_addr=0x1234 and sdram_rdata=0xDEADBEEF:
  - rd_n=0 and address=0x1234 at phase 1;
  - rd_valid=1 with rd_data=0xDEADBEEF at phase 9 only.
REQ-031 Write (0x0100, 0x5A) pushed at phase 3 -> wr_n=0, address=0x0100, wdata=0x5A at phase 9; the following phase-8 slot with an empty buffer issues rfsh_n=0.
REQ-032 Writes kept continuously pending with RFSH_MAX=8 -> slots 1-8 are writes, slot 9 is a refresh, slot 10 is a write.
REQ-033 FIFO_EN build:
  - push 4 writes back-to-back -> wr_ready=0 after the 4th;
  - pops occur in order at successive phase-8 slots;
  - wr_ready=1 the cycle after the first pop.
  - Non-FIFO build: wr_ready=0 after 1 push.
REQ-034 init_busy=1 with rd_req=1 and a pending write -> no strobes and rd_valid=0; after init_busy falls, the write goes out at the next phase 9.
REQ-035 Edge cases:
  - line_start at phase 5 -> phase=0 next cycle;
  - rst pulse at phase 1 of a read -> strobes return to 1 immediately and no rd_valid occurs.
